// File: rtl/qkv_seq_ctrl.sv
// qkv_seq_ctrl: sequences weight/input loading, the QKV projection run and the streamed readout of results.
// Optional RUN watchdog enabled by defining QKV_SEQ_CTRL_TIMEOUT_EN.
module qkv_seq_ctrl #(
    parameter int W_DEPTH        = 1024,
    parameter int IN_DEPTH       = 32,
    parameter int OUT_DEPTH      = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         ld_valid,
    output logic         ld_ready,
    output logic         init,
    output logic         init_w_wen,
    output logic         init_input_wen,
    output logic [9:0]   init_w_addr,
    output logic [4:0]   init_input_addr,
    output logic         en,
    input  logic         finished_q,
    input  logic         finished_k,
    input  logic         finished_v,
    output logic         fin,
    output logic         fin_output_wen,
    output logic [6:0]   fin_output_addr,
    input  logic [127:0] OUTPUT_MEM_DOUT_q,
    input  logic [127:0] OUTPUT_MEM_DOUT_k,
    input  logic [127:0] OUTPUT_MEM_DOUT_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [383:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_IN, RUN, DRAIN, DONE, ERR} state_t;
    localparam logic [9:0] W_LAST   = 10'(W_DEPTH - 1);
    localparam logic [4:0] IN_LAST  = 5'(IN_DEPTH - 1);
    localparam logic [6:0] OUT_LAST = 7'(OUT_DEPTH - 1);
    state_t state, state_n;
    logic [9:0] w_addr;
    logic [4:0] in_addr;
    logic [6:0] rd_addr;
    logic [2:0] flags, flags_n;
    logic rd_live, all_cap, cap, timeout;
    assign flags_n = flags | {finished_v, finished_k, finished_q};
    // The memory re-reads the presented address every cycle, so an uncaptured word is simply read again.
    assign cap = state == DRAIN && rd_live && !all_cap && (!out_valid || out_ready);
    assign fin_output_wen = 1'b1;
    assign init_w_addr = w_addr;
    assign init_input_addr = in_addr;
`ifdef QKV_SEQ_CTRL_TIMEOUT_EN
    logic [31:0] run_cnt;
    always_ff @(posedge clk)
        run_cnt <= (rst || state != RUN) ? 32'd0 : run_cnt + 32'd1;
    assign timeout = run_cnt == 32'(TIMEOUT_CYCLES - 1);
    assign err = state == ERR;
`else
    assign timeout = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        init = 1'b0;
        ld_ready = 1'b0;
        init_w_wen = 1'b1;
        init_input_wen = 1'b1;
        en = 1'b0;
        fin = 1'b0;
        fin_output_addr = 7'd0;
        done = 1'b0;
        busy = state != IDLE && state != ERR;
        case (state)
            IDLE: state_n = start ? LOAD_W : IDLE;
            LOAD_W: begin
                init = 1'b1;
                ld_ready = 1'b1;
                init_w_wen = !ld_valid;
                state_n = (ld_valid && w_addr == W_LAST) ? LOAD_IN : LOAD_W;
            end
            LOAD_IN: begin
                init = 1'b1;
                ld_ready = 1'b1;
                init_input_wen = !ld_valid;
                state_n = (ld_valid && in_addr == IN_LAST) ? RUN : LOAD_IN;
            end
            RUN: begin
                en = 1'b1;
                state_n = &flags_n ? DRAIN : timeout ? ERR : RUN;
            end
            DRAIN: begin
                fin = 1'b1;
                fin_output_addr = (cap && rd_addr != OUT_LAST) ? rd_addr + 7'd1 : rd_addr;
                state_n = (out_valid && out_ready && out_last) ? DONE : DRAIN;
            end
            DONE: begin
                done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            w_addr <= '0;
            in_addr <= '0;
            rd_addr <= '0;
            flags <= '0;
            rd_live <= 1'b0;
            all_cap <= 1'b0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            if (state == LOAD_W && ld_valid && w_addr != W_LAST)
                w_addr <= w_addr + 10'd1;
            if (state == LOAD_IN && ld_valid && in_addr != IN_LAST)
                in_addr <= in_addr + 5'd1;
            flags <= state == RUN ? flags_n : 3'b0;
            rd_live <= state == DRAIN;
            if (cap) begin
                out_data <= {OUTPUT_MEM_DOUT_v, OUTPUT_MEM_DOUT_k, OUTPUT_MEM_DOUT_q};
                out_last <= rd_addr == OUT_LAST;
                all_cap <= rd_addr == OUT_LAST;
                rd_addr <= fin_output_addr;
            end
            out_valid <= cap || (out_valid && !out_ready);
        end
    end
endmodule

// File: tb/tb_qkv_seq_ctrl.sv
// tb_qkv_seq_ctrl: randomized self-checking bench against a job-level model of load, run and readout.
module tb_qkv_seq_ctrl;
    localparam int WD = 1024, ID = 32, OD = 128;
    logic clk = 0, rst = 1, start = 0, ld_valid = 0, out_ready = 0;
    logic finished_q = 0, finished_k = 0, finished_v = 0;
    logic ld_ready, init, init_w_wen, init_input_wen, en, fin, fin_output_wen;
    logic out_valid, out_last, busy, done, err;
    logic [9:0] init_w_addr;
    logic [4:0] init_input_addr;
    logic [6:0] fin_output_addr;
    logic [383:0] out_data;
    logic [127:0] dq, dk, dv;
    logic [127:0] mem_q [OD], mem_k [OD], mem_v [OD];
    int checks = 0, errors = 0;

    qkv_seq_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .init(init), .init_w_wen(init_w_wen), .init_input_wen(init_input_wen),
        .init_w_addr(init_w_addr), .init_input_addr(init_input_addr), .en(en),
        .finished_q(finished_q), .finished_k(finished_k), .finished_v(finished_v),
        .fin(fin), .fin_output_wen(fin_output_wen), .fin_output_addr(fin_output_addr),
        .OUTPUT_MEM_DOUT_q(dq), .OUTPUT_MEM_DOUT_k(dk), .OUTPUT_MEM_DOUT_v(dv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    // Output memories: synchronous read, one-cycle latency
    always @(posedge clk) begin
        dq <= mem_q[fin_output_addr];
        dk <= mem_k[fin_output_addr];
        dv <= mem_v[fin_output_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {init, en, fin, init_w_wen, init_input_wen, fin_output_wen,
                              ld_ready, out_valid, out_last, busy, done, err}, 12'b000111000000);
        check({tag, "_addr"}, {init_w_addr, init_input_addr, fin_output_addr}, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    task automatic start_job;
        for (int i = 0; i < OD; i++) begin
            mem_q[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_k[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_v[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        start = 1;
        step;
        start = 0;
    endtask

    // Model: the n-th accepted beat writes address n of the current memory; idle beats write nothing.
    task automatic load(input bit gap);
        int nw = 0, ni = 0, cyc = 0;
        while (ni < ID && cyc < 4000) begin
            ld_valid = gap ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            if (nw < WD) begin
                check("ld_w", {init, ld_ready, init_w_wen, init_input_wen, init_w_addr},
                      {2'b11, ~ld_valid, 1'b1, 10'(nw)});
                if (ld_valid) nw++;
            end else begin
                check("ld_in", {init, ld_ready, init_w_wen, init_input_wen, init_input_addr},
                      {2'b11, 1'b1, ~ld_valid, 5'(ni)});
                if (ld_valid) ni++;
            end
            cyc++;
            step;
        end
        ld_valid = 0;
        check("ld_beats", nw + ni, WD + ID);
    endtask

    task automatic run_phase(input int tq, input int tk, input int tv);
        int last = tq > tk ? tq : tk;
        last = last > tv ? last : tv;
        for (int c = 0; c <= last; c++) begin
            finished_q = c == tq;
            finished_k = c == tk;
            finished_v = c == tv;
            @(negedge clk);
            check("run", {en, fin, init, busy, err}, 5'b10010);
            step;
        end
        {finished_q, finished_k, finished_v} = 3'b000;
    endtask

    task automatic drain(input bit full, input int stop_at);
        int idx = 0, c = 0;
        bit hv = 0;
        logic [383:0] held = 0;
        out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        check("drain_entry", {en, fin, fin_output_wen, busy}, 4'b0111);
        while (c < 3000) begin
            check("drain_done_low", done, 0);
            if (stop_at >= 0 && fin_output_addr >= 7'(stop_at)) return;
            if (full)
                check("rate", {out_valid, 7'(idx)}, {c >= 2, 7'(c >= 2 ? c - 2 : 0)});
            if (out_valid) begin
                check("data", out_data, {mem_v[idx], mem_k[idx], mem_q[idx]});
                check("last", out_last, idx == OD - 1);
                if (hv) check("stable", out_data, held);
                hv = !out_ready;
                held = out_data;
                if (out_ready) begin
                    idx++;
                    if (idx == OD) break;
                end
            end
            step;
            out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            c++;
            @(negedge clk);
        end
        check("drain_count", idx, OD);
        step;
        @(negedge clk);
        check("done", {done, busy, fin}, 3'b110);
        step;
        @(negedge clk);
        check("idle", {done, busy, fin, out_valid}, 4'b0000);
        step;
    endtask

    initial begin
        repeat (2) step;
        @(negedge clk);
        check_reset("por");
        step;
        rst = 0;
        step;
        // k first, then q and v together
        start_job;
        load(0);
        run_phase(3, 0, 3);
        drain(0, -1);
        start_job;
        load(1);
        run_phase($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
        drain(1, -1);
        // reset in the middle of readout
        start_job;
        load(0);
        run_phase(0, 0, 0);
        drain(0, 40);
        rst = 1;
        step;
        rst = 0;
        @(negedge clk);
        check_reset("mid_rst");
        step;
        start_job;
        load(0);
        run_phase(2, 1, 0);
        drain(0, -1);
`ifdef QKV_SEQ_CTRL_TIMEOUT_EN
        start_job;
        load(0);
        for (int c = 1; c <= 100; c++) begin
            finished_q = c == 1;
            finished_k = c == 5;
            @(negedge clk);
            check("to_run", {en, err}, 2'b10);
            step;
        end
        {finished_q, finished_k} = 2'b00;
        @(negedge clk);
        check("to_err", {err, en, busy}, 3'b100);
        step;
        start = 1;
        step;
        start = 0;
        repeat (3) step;
        @(negedge clk);
        check("err_sticky", {err, en, busy, ld_ready}, 4'b1000);
        step;
        rst = 1;
        step;
        rst = 0;
        @(negedge clk);
        check_reset("err_rst");
        step;
`else
        start_job;
        load(0);
        run_phase(0, 0, 150);
        drain(1, -1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qkv_seq_ctrl.md
QKV_SEQ_CTRL -- requirements
Module: qkv_seq_ctrl

Interface
REQ-001 SHALL have parameter W_DEPTH, default 1024, weight words loaded per projection.
REQ-002 SHALL have parameter IN_DEPTH, default 32, input words loaded.
REQ-003 SHALL have parameter OUT_DEPTH, default 128, output words read back.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, RUN watchdog limit.
REQ-005 SHALL have port clk  in  1  the single clock; all logic rising-edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1  one-cycle request to begin a full load/run/readout job.
REQ-008 SHALL have port ld_valid / ld_ready  in/out  1/1  host load-beat handshake; DIN buses go from host straight to the memories.
REQ-009 SHALL have ports init, init_w_wen, init_input_wen  out  1 each  memory-load mux select and active-low write enables.
REQ-010 SHALL have ports init_w_addr / init_input_addr  out  10/5  load addresses.
REQ-011 SHALL have port en  out  1  enable to all three projection engines.
REQ-012 SHALL have ports finished_q, finished_k, finished_v  in  1 each  per-engine completion, pulse or level.
REQ-013 SHALL have ports fin, fin_output_wen, fin_output_addr  out  1/1/7  readout mux select, write-enable held 1 (read), and read address.
REQ-014 SHALL have ports OUTPUT_MEM_DOUT_q/k/v  in  128 each  memory read data, 1-cycle latency.
REQ-015 SHALL have ports out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/384/1  readout stream; out_data = {v,k,q}.
REQ-016 SHALL have ports busy, done, err  out  1 each  status.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD_W -> LOAD_IN -> RUN -> DRAIN -> DONE -> IDLE, plus ERR.
REQ-018 IDLE: start -> LOAD_W; start ignored in all other states.
REQ-019 LOAD_W/LOAD_IN: init=1, ld_ready=1; on ld_valid&ld_ready the active wen=0 in the same cycle at the current counter address, counter increments.
REQ-020 LOAD_W SHALL accept exactly W_DEPTH beats (addr 0..W_DEPTH-1), then LOAD_IN accepts IN_DEPTH beats; no idle cycle between phases.
REQ-021 ld_valid=0 SHALL hold address and keep both wen=1 (no write).
REQ-022 RUN: init=0, en=1; per-engine sticky flag set on finished_x=1; all three flags set -> DRAIN next cycle with en=0.
REQ-023 Finished pulses arriving in the same cycle or in any order SHALL each be captured.
REQ-024 DRAIN: fin=1, fin_output_wen=1; read issued at fin_output_addr when no read in flight and output register empty or being popped this cycle.
REQ-025 Read data SHALL be captured one cycle after issue into a single output register; out_valid held until out_ready.
REQ-026 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 out_last=1 with the word from address OUT_DEPTH-1; its handshake -> DONE.
REQ-028 With out_ready held 1, SHALL sustain one word per cycle after a 2-cycle initial latency from DRAIN entry.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 busy=1 in every state except IDLE and ERR.
REQ-031 Address counters SHALL never exceed depth-1; no wrap to 0 within a phase.

Reset
REQ-032 rst=1 at any clock edge, mid-operation included, SHALL force IDLE next cycle, clear counters and flags, and empty the output register.
REQ-033 Reset values: init=0, en=0, fin=0, init_w_wen=1, init_input_wen=1, fin_output_wen=1, all addresses 0, ld_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, err=0.
REQ-034 ERR SHALL be left only via rst.

Configuration
REQ-035 Macro QKV_SEQ_CTRL_TIMEOUT_EN defined: a RUN cycle counter SHALL move to ERR (err=1, en=0) when it reaches TIMEOUT_CYCLES without all three flags set.
REQ-036 Macro undefined: no counter; RUN waits indefinitely; err SHALL be tied 0.

Verification
REQ-037 start, ld_valid held 1 -> 1024 weight writes at addrs 0..1023 then 32 input writes at 0..31 on consecutive cycles, init=1 throughout.
REQ-038 ld_valid toggled every other cycle during LOAD_W -> no write on idle cycles, address does not advance, total writes still 1024.
REQ-039 finished_k pulse, then finished_q and finished_v in the same later cycle -> DRAIN entered one cycle later, en drops.
REQ-040 out_ready random 50% -> 128 words in address order, data stable while stalled, out_last only on word 127, done pulse once.
REQ-041 rst asserted mid-DRAIN at addr 40 -> IDLE next cycle, all outputs at reset values, a new start completes a full job.
REQ-042 With QKV_SEQ_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, finished_v never asserted -> err=1 and en=0 after 100 RUN cycles; start ignored until rst.
